ddr3_app_master: RTL

- User-side initiator for the DDR3 controller's application (UI) interface, clocked in the controller's ui_clk domain.
- Converts a simple valid/ready request port (one 128-bit beat per request) into correctly sequenced app_cmd/app_en and app_wdf_* handshakes.
- Tracks outstanding reads and returns read data in order on a response port.
- Sits between the compute-side logic and the memory controller's app_* ports.

---
 rtl/ddr3_app_master.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ddr3_app_master.sv
// ddr3_app_master: single-beat request port to DDR3 UI app_* handshakes.
// Reads are counted and their data returned in order on rsp_*.
module ddr3_app_master #(
  parameter int ADDR_WIDTH         = 28,
  parameter int DATA_WIDTH         = 128,
  parameter int MASK_WIDTH         = DATA_WIDTH / 8,
  parameter int MAX_RD_OUTSTANDING = 8
) (
  input  logic                  ui_clk,
  input  logic                  sys_rst,
  input  logic                  init_calib_complete,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [MASK_WIDTH-1:0] req_wmask,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  wr_done,
  output logic                  err_unexpected_rd,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [DATA_WIDTH-1:0] app_wdf_data,
  output logic [MASK_WIDTH-1:0] app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0] app_rd_data,
  input  logic                  app_rd_data_valid,
  input  logic                  app_rd_data_end,
  output logic                  app_sr_req,
  output logic                  app_ref_req,
  output logic                  app_zq_req
);

  localparam int CW = $clog2(MAX_RD_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_RD_OUTSTANDING);
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    S_WAIT_CAL,
    S_IDLE,
    S_WR,
    S_RD,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] rd_cnt;
  logic          cmd_done;
  logic          data_done;
  logic          is_wr;
  logic          accept;
  logic          cmd_hs;
  logic          wdf_hs;
  logic          rd_inc;
  logic          rd_dec;
  logic          rd_end_unused;

  assign rd_end_unused = app_rd_data_end;

  assign accept = req_valid & req_ready;
  assign cmd_hs = app_en & app_rdy;
  assign wdf_hs = app_wdf_wren & app_wdf_rdy;
  assign rd_inc = (state == S_RD) & cmd_hs;
  assign rd_dec = app_rd_data_valid & (rd_cnt != '0);

  always_ff @(posedge ui_clk) begin
    if (!sys_rst) begin
      state <= S_WAIT_CAL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_WAIT_CAL: begin
        if (init_calib_complete) state_nx = S_IDLE;
      end
      S_IDLE: begin
        if (!init_calib_complete) begin
          state_nx = S_WAIT_CAL;
        end else if (accept) begin
          state_nx = req_we ? S_WR : S_RD;
        end
      end
      S_WR: begin
        // Command and data channels finish independently.
        if ((cmd_done | cmd_hs) & (data_done | wdf_hs))
          state_nx = S_DONE;
      end
      S_RD: begin
        if (cmd_hs) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = init_calib_complete ? S_IDLE : S_WAIT_CAL;
      end
      default: state_nx = S_WAIT_CAL;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    wr_done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = init_calib_complete & (rd_cnt < MAX_CNT);
      end
      S_WR: begin
        app_en       = ~cmd_done;
        app_wdf_wren = ~data_done;
      end
      S_RD: begin
        app_en = 1'b1;
      end
      S_DONE: begin
        wr_done = is_wr;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  assign app_wdf_end = app_wdf_wren;

  always_ff @(posedge ui_clk) begin
    if (!sys_rst) begin
      app_addr     <= '0;
      app_cmd      <= CMD_WR;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      is_wr        <= 1'b0;
      cmd_done     <= 1'b0;
      data_done    <= 1'b0;
    end else if (accept) begin
      app_addr  <= req_addr;
      app_cmd   <= req_we ? CMD_WR : CMD_RD;
      is_wr     <= req_we;
      cmd_done  <= 1'b0;
      data_done <= 1'b0;
      if (req_we) begin
        app_wdf_data <= req_wdata;
        app_wdf_mask <= req_wmask;
      end
    end else begin
      if (cmd_hs) cmd_done <= 1'b1;
      if (wdf_hs) data_done <= 1'b1;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (!sys_rst) begin
      rd_cnt            <= '0;
      rsp_valid         <= 1'b0;
      rsp_rdata         <= '0;
      err_unexpected_rd <= 1'b0;
    end else begin
      rsp_valid <= app_rd_data_valid;
      if (app_rd_data_valid) rsp_rdata <= app_rd_data;
      // Stray data is still forwarded; the count saturates at zero.
      if (app_rd_data_valid & (rd_cnt == '0))
        err_unexpected_rd <= 1'b1;
      if (rd_inc & ~rd_dec) begin
        rd_cnt <= rd_cnt + CW'(1);
      end else if (rd_dec & ~rd_inc) begin
        rd_cnt <= rd_cnt - CW'(1);
      end
    end
  end

  assign app_sr_req  = 1'b0;
  assign app_ref_req = 1'b0;
  assign app_zq_req  = 1'b0;

endmodule
